// File: rtl/chg_capture_fifo.sv
// Change-capture FIFO: samples smp_data every cycle and buffers {ts, data} records on value changes.
// Optional CHGCAP_DROP_CNT_EN adds a saturating 8-bit drop_cnt output.
module chg_capture_fifo #(
   parameter int DATA_W = 32,
   parameter int TS_W   = 16,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [DATA_W-1:0]          smp_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [TS_W-1:0]            out_ts,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
`ifdef CHGCAP_DROP_CNT_EN
   output logic [7:0]                 drop_cnt,
`endif
   input  logic                       clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [TS_W-1:0]   ts;
   logic [DATA_W-1:0] prev;
   logic              armed;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [TS_W-1:0]   mem_ts   [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      capture = en && (!armed || (smp_data != prev));
      full    = (count == CW'(DEPTH));
      pop     = out_valid && out_ready;
      // a full FIFO still accepts a record when the head leaves in the same cycle
      push    = capture && (!full || pop);
      drop    = capture && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= '0;
         armed <= 1'b0;
      end else if (en) begin
         prev  <= smp_data;
         armed <= 1'b1;
      end else begin
         armed <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= smp_data;
         mem_ts[wr_ptr]   <= ts;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

`ifdef CHGCAP_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop) begin
         if (clr_ovf) begin
            drop_cnt <= 8'd1;
         end else if (drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (clr_ovf) begin
         drop_cnt <= '0;
      end
   end
`endif

   // storage is not reset, so the head is masked to zero whenever the FIFO is empty
   always_comb begin
      out_valid = (count != '0);
      out_data  = out_valid ? mem_data[rd_ptr] : '0;
      out_ts    = out_valid ? mem_ts[rd_ptr]   : '0;
   end

endmodule

// File: tb/tb_chg_capture_fifo.sv
// Directed bench for chg_capture_fifo: table of per-cycle vectors plus reset and overflow sequences.
module tb_chg_capture_fifo;

   localparam int DATA_W = 32;
   localparam int TS_W   = 4;
   localparam int DEPTH  = 8;
   localparam int NV     = 50;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [DATA_W-1:0] smp_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [TS_W-1:0]   out_ts;
   logic [3:0]        count;
   logic              overflow;
   logic              clr_ovf;
`ifdef CHGCAP_DROP_CNT_EN
   logic [7:0]        drop_cnt;
`endif

   chg_capture_fifo #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .smp_data  (smp_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ts    (out_ts),
      .count     (count),
      .overflow  (overflow),
`ifdef CHGCAP_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [31:0] data;
      logic        rdy;
      logic        clr;
      logic        e_valid;
      logic [31:0] e_data;
      logic [3:0]  e_ts;
      logic [3:0]  e_count;
      logic        e_ovf;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t tv [NV];
   int n_applied = 0;
   int n_miscompare = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [31:0] d,
                       input logic rdy, input logic clr);
      @(negedge clk);
      rst = r; en = e; smp_data = d; out_ready = rdy; clr_ovf = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [31:0] d,
                            input logic [3:0] t, input logic [3:0] c, input logic o);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".data"},  out_data, d);
      chk({tag, ".ts"},    32'(out_ts), 32'(t));
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".ovf"},   32'(overflow), 32'(o));
   endtask

   task automatic setv(input int i, input logic e, input logic [31:0] d, input logic rdy,
                       input logic clr, input logic ev, input logic [31:0] ed,
                       input int et, input int ec, input logic eo, input int edr);
      tv[i].en = e; tv[i].data = d; tv[i].rdy = rdy; tv[i].clr = clr;
      tv[i].e_valid = ev; tv[i].e_data = ed; tv[i].e_ts = 4'(et);
      tv[i].e_count = 4'(ec); tv[i].e_ovf = eo; tv[i].e_drop = 8'(edr);
   endtask

   initial begin
      // held value: one record {ts 0, data 0}
      for (int i = 0; i < 10; i++) setv(i, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      // incrementing data drained every cycle; ts wraps at 16
      for (int i = 10; i <= 20; i++) setv(i, 1, 32'(i - 9), 1, 0, 1, 32'(i - 9), i % 16, 1, 0, 0);
      setv(21, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0);
      // ten distinct values into an 8-deep FIFO with no consumer
      for (int i = 22; i <= 31; i++)
         setv(i, 1, 32'(100 + i - 22), 0, 0, 1, 100, 6, (i - 21 > 8) ? 8 : i - 21,
              (i >= 30), (i >= 30) ? i - 29 : 0);
      setv(32, 1, 200, 1, 0, 1, 101, 7, 8, 1, 2);
      setv(33, 0, 200, 0, 1, 1, 101, 7, 8, 0, 0);
      for (int j = 1; j <= 6; j++) setv(33 + j, 0, 200, 1, 0, 1, 32'(101 + j), 7 + j, 8 - j, 0, 0);
      setv(40, 0, 200, 1, 0, 1, 200, 0, 1, 0, 0);
      setv(41, 0, 200, 1, 0, 0, 0, 0, 0, 0, 0);
      // en low with a constant value, re-enable recaptures
      setv(42, 1, 5, 0, 0, 1, 5, 10, 1, 0, 0);
      setv(43, 1, 5, 0, 0, 1, 5, 10, 1, 0, 0);
      for (int i = 44; i <= 46; i++) setv(i, 0, 5, 0, 0, 1, 5, 10, 1, 0, 0);
      setv(47, 1, 5, 0, 0, 1, 5, 10, 2, 0, 0);
      setv(48, 1, 5, 1, 0, 1, 5, 15, 1, 0, 0);
      setv(49, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);

      rst = 1'b1; en = 1'b0; smp_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", 0, 0, 0, 0, 0);
`ifdef CHGCAP_DROP_CNT_EN
      chk("reset.drop_cnt", 32'(drop_cnt), 0);
`endif

      for (int i = 0; i < NV; i++) begin
         step(0, tv[i].en, tv[i].data, tv[i].rdy, tv[i].clr);
         chk_state($sformatf("v%0d", i), tv[i].e_valid, tv[i].e_data, tv[i].e_ts,
                   tv[i].e_count, tv[i].e_ovf);
`ifdef CHGCAP_DROP_CNT_EN
         chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(tv[i].e_drop));
`endif
      end

      // reset with three stored records discards them; next enabled cycle captures at ts 0
      step(0, 1, 1, 0, 0);
      step(0, 1, 2, 0, 0);
      step(0, 1, 3, 0, 0);
      chk("pre_rst.count", 32'(count), 3);
      step(1, 1, 3, 0, 0);
      chk_state("mid_rst", 0, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0);
      chk_state("post_rst", 1, 3, 0, 1, 0);

      // fill, then a drop coinciding with clr_ovf: set wins, drop_cnt restarts at 1
      for (int k = 0; k < 7; k++) step(0, 1, 32'(10 + k), 0, 0);
      chk_state("refill", 1, 3, 0, 8, 0);
      step(0, 1, 17, 0, 1);
      chk_state("drop_clr", 1, 3, 0, 8, 1);
`ifdef CHGCAP_DROP_CNT_EN
      chk("drop_clr.drop_cnt", 32'(drop_cnt), 1);
`endif
      step(0, 0, 17, 0, 1);
      chk_state("clr_only", 1, 3, 0, 8, 0);
`ifdef CHGCAP_DROP_CNT_EN
      chk("clr_only.drop_cnt", 32'(drop_cnt), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
      $finish;
   end

endmodule

// File: doc/chg_capture_fifo.md
Name: chg_capture_fifo

Overview:
- Hardware counterpart of the bench-side value monitor: samples a data bus every cycle and captures a timestamped record whenever the value changes.
- Records are buffered in a small FIFO and drained by a consumer over a valid/ready interface.
- Sits beside a DUT output bus, so on-chip logic or a debug port can read back the change history instead of relying on simulation-only monitoring.

Parameters:
- DATA_W, 32, width of sampled bus and stored data field.
- TS_W, 16, width of free-running timestamp counter and stored timestamp field.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  capture enable.
- smp_data  input  DATA_W  sampled bus.
- out_valid  output  1  FIFO head holds a record.
- out_ready  input  1  consumer accepts the head record.
- out_data  output  DATA_W  data field of head record.
- out_ts  output  TS_W  timestamp field of head record.
- count  output  clog2(DEPTH)+1  number of stored records.
- overflow  output  1  sticky; a record was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at an edge):
  - ts counter, prev register, FIFO pointers, count, overflow and armed all go to 0.
  - out_valid=0; out_data and out_ts read 0.
- Timestamp:
  - ts increments by 1 every cycle after reset, regardless of en.
  - Wraps from 2^TS_W-1 to 0 with no flag.
  - A record stores the ts value of the cycle in which smp_data was sampled.
- Change detection:
  - While en=1, prev <= smp_data every cycle and armed <= 1.
  - While en=0, prev holds and armed <= 0.
  - Capture condition: en=1 and (armed=0 or smp_data != prev).
  - The first enabled cycle after reset or after en was low is therefore always captured.
- Push: a capture writes {ts, smp_data} into the FIFO at the end of that cycle.
  - Latency: the record is visible at the head (out_valid=1) in the cycle after capture if the FIFO was empty.
- Pop: occurs when out_valid=1 and out_ready=1. out_ready with out_valid=0 has no effect.
- Output path:
  - First-word-fall-through; out_data and out_ts are driven from the storage head.
  - out_data and out_ts hold stable while out_valid=1 and out_ready=0.
- Full (count==DEPTH):
  - Capture with a simultaneous pop: push is accepted and count stays DEPTH.
  - Capture with no pop: record is dropped, overflow <= 1, and FIFO contents are unchanged.
- Empty: a simultaneous push and pop is impossible because out_valid=0, so count becomes 1.
- count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it.
- Reset mid-operation discards all stored records. The first enabled cycle after reset captures.

Optional Feature:
- Macro CHGCAP_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 8 bits, reset 0.
  - Increments on every dropped record and saturates at 255.
  - Cleared by clr_ovf in cycles with no drop.
  - A drop in the same cycle as clr_ovf yields drop_cnt=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, en=1, smp_data held at 0x00000000 for 10 cycles, out_ready=0:
  - Exactly one record {ts=0, data=0}.
  - count=1, out_valid=1 from cycle 1.
- smp_data increments by 1 each cycle 0..10, out_ready=1:
  - 11 records in order, data 0..10 with consecutive ts.
  - count never exceeds 1; overflow=0.
- out_ready=0, DEPTH=8, 10 distinct values:
  - count=8, overflow=1.
  - Drain yields the first 8 values in order; with CHGCAP_DROP_CNT_EN, drop_cnt=2.
- Full FIFO, new change with out_ready=1 in the same cycle:
  - count stays 8, no drop, and the new record is last out.
- en toggled low for 3 cycles while smp_data=0x5, then high with the same value:
  - A new record with data 0x5 is captured on re-enable.
  - No records are captured while en=0.
- ts wrap with TS_W=4:
  - A change at cycle 17 records ts=1.
  - rst asserted with 3 stored records gives count=0 and out_valid=0 the next cycle.
